// File: rtl/pwm_cfg_arbiter.sv
// pwm_cfg_arbiter: PWM configuration register bank (0x00..0x06) shared between
// the SPI host write port and a duty-cycle ramp engine.
// Build option PWM_CFG_RAMP_EN: when defined, the ramp engine, the 0x05/0x06
// registers and host/ramp round-robin arbitration are present. When undefined,
// the host owns the bank alone and ramp outputs are tied low.
module pwm_cfg_arbiter #(
  parameter int unsigned PRESCALE = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_valid,
  input  logic [6:0] host_addr,
  input  logic [7:0] host_data,
  output logic       host_ready,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic [7:0] ramp_target,
  output logic [7:0] ramp_div,
  output logic       ramp_busy
);

  logic host_wr;
  assign host_wr = host_valid && host_ready;

  // Output/PWM enable registers: written only by the host
  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg_out_7_0  <= 8'h00;
      en_reg_out_15_8 <= 8'h00;
      en_reg_pwm_7_0  <= 8'h00;
      en_reg_pwm_15_8 <= 8'h00;
    end else if (host_wr) begin
      case (host_addr)
        7'h00:   en_reg_out_7_0  <= host_data;
        7'h01:   en_reg_out_15_8 <= host_data;
        7'h02:   en_reg_pwm_7_0  <= host_data;
        7'h03:   en_reg_pwm_15_8 <= host_data;
        default: ;
      endcase
    end
  end

`ifdef PWM_CFG_RAMP_EN
  localparam int CNT_W = $clog2(256 * PRESCALE);

  typedef enum logic [1:0] {IDLE, WAIT, REQ} ramp_st_t;

  ramp_st_t         st;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wait_lim;
  logic             last_ramp;
  logic             ramp_req;
  logic             ramp_win;
  logic [7:0]       duty_step;

  // Move one code toward the target, saturating at the target itself
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt)      return cur + 8'd1;
    else if (cur > tgt) return cur - 8'd1;
    else                return cur;
  endfunction

  // Last WAIT count before a step is requested; tracks ramp_div live
  assign wait_lim  = CNT_W'((32'(ramp_div) + 32'd1) * PRESCALE - 32'd1);
  assign ramp_req  = (st == REQ);
  // On contention the requester not granted most recently wins
  assign ramp_win  = ramp_req && (!host_valid || !last_ramp);
  assign host_ready = !ramp_win;
  assign ramp_busy = (st != IDLE);
  assign duty_step = step_toward(pwm_duty_cycle, ramp_target);

  // Ramp registers, round-robin flag and ramp FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_duty_cycle <= 8'h00;
      ramp_target    <= 8'h00;
      ramp_div       <= 8'h00;
      st             <= IDLE;
      cnt            <= '0;
      last_ramp      <= 1'b0;
    end else begin
      if (ramp_win)        last_ramp <= 1'b1;
      else if (host_valid) last_ramp <= 1'b0;

      if (host_wr) begin
        case (host_addr)
          7'h04:   pwm_duty_cycle <= host_data;
          7'h05:   ramp_target    <= host_data;
          7'h06:   ramp_div       <= host_data;
          default: ;
        endcase
      end
      if (ramp_win) pwm_duty_cycle <= duty_step;

      case (st)
        IDLE: begin
          if (host_wr && host_addr == 7'h05 && host_data != pwm_duty_cycle) begin
            st  <= WAIT;
            cnt <= '0;
          end
        end
        WAIT: begin
          // >= so a smaller ramp_div written mid-wait still fires promptly
          if (cnt >= wait_lim) st  <= REQ;
          else                 cnt <= cnt + 1'b1;
        end
        REQ: begin
          if (ramp_win) begin
            if (duty_step == ramp_target) begin
              st <= IDLE;
            end else begin
              st  <= WAIT;
              cnt <= '0;
            end
          end
        end
        default: st <= IDLE;
      endcase

      // Host duty overwrite aborts; retarget onto the current duty also ends the ramp
      if (host_wr && st != IDLE) begin
        if (host_addr == 7'h04) st <= IDLE;
        else if (host_addr == 7'h05 && host_data == pwm_duty_cycle) st <= IDLE;
      end
    end
  end
`else
  assign host_ready  = 1'b1;
  assign ramp_target = 8'h00;
  assign ramp_div    = 8'h00;
  assign ramp_busy   = 1'b0;

  // Duty register: host-owned when no ramp engine is built
  always_ff @(posedge clk) begin
    if (rst)                                pwm_duty_cycle <= 8'h00;
    else if (host_wr && host_addr == 7'h04) pwm_duty_cycle <= host_data;
  end
`endif

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Testbench for pwm_cfg_arbiter: per-cycle expected outputs from a reference
// model are queued by the stimulus process and checked by a negedge monitor.
module tb_pwm_cfg_arbiter;
  localparam int unsigned P = 4;
`ifdef PWM_CFG_RAMP_EN
  localparam bit RAMP_EN = 1'b1;
`else
  localparam bit RAMP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_valid = 1'b0;
  logic [6:0] host_addr = '0;
  logic [7:0] host_data = '0;
  logic       host_ready;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle, ramp_target, ramp_div;
  logic       ramp_busy;

  pwm_cfg_arbiter #(.PRESCALE(P)) dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_addr(host_addr), .host_data(host_data),
    .host_ready(host_ready),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .ramp_target(ramp_target),
    .ramp_div(ramp_div), .ramp_busy(ramp_busy)
  );

  always #5 clk = ~clk;

  // Reference model state: register bank, whether a ramp is in progress,
  // whether a step is pending arbitration, the cycle the current wait began
  // and who won the last grant.
  logic [7:0]  m_reg [0:6];
  bit          m_busy, m_req, m_last;
  int          m_ws, cyc;
  logic [57:0] sb [$];
  int          vectors, miscompares;

  task automatic model_reset();
    for (int i = 0; i < 7; i++) m_reg[i] = 8'h00;
    m_busy = 0; m_req = 0; m_last = 0; m_ws = 0;
  endtask

  task automatic model_cycle(input bit r, input bit hv, input logic [6:0] a,
                             input logic [7:0] d, output logic [57:0] exp);
    bit         win, rdy, wr;
    logic [7:0] od, nd;
    int         lim;
    win = RAMP_EN && m_busy && m_req && (!hv || !m_last);
    rdy = !win;
    exp = {rdy, m_busy, m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_reg[4], m_reg[5], m_reg[6]};
    if (r) begin
      model_reset();
    end else begin
      wr  = hv && rdy;
      od  = m_reg[4];
      lim = (int'(m_reg[6]) + 1) * int'(P) - 1;
      if (win) m_last = 1; else if (hv) m_last = 0;
      if (wr && (a <= 7'd4 || (RAMP_EN && a <= 7'd6))) m_reg[a] = d;
      if (RAMP_EN && m_busy) begin
        if (win) begin
          nd = od;
          if (nd < m_reg[5]) nd = nd + 8'd1;
          else if (nd > m_reg[5]) nd = nd - 8'd1;
          m_reg[4] = nd;
          if (nd == m_reg[5]) m_busy = 0;
          else begin m_req = 0; m_ws = cyc + 1; end
        end else if (!m_req && (cyc - m_ws) >= lim) begin
          m_req = 1;
        end
        if (wr && (a == 7'd4 || (a == 7'd5 && d == od))) m_busy = 0;
      end else if (RAMP_EN && wr && a == 7'd5 && d != od) begin
        m_busy = 1; m_req = 0; m_ws = cyc + 1;
      end
    end
    cyc++;
  endtask

  task automatic drive(input bit r, input bit hv, input logic [6:0] a, input logic [7:0] d);
    logic [57:0] exp;
    @(posedge clk);
    #1;
    rst = r; host_valid = hv; host_addr = a; host_data = d;
    model_cycle(r, hv, a, d, exp);
    sb.push_back(exp);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    drive(0, 1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 7'h00, 8'h00);
  endtask

  // Monitor: compare every presented cycle against the queued expectation
  always @(negedge clk) begin
    logic [57:0] act, e;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {host_ready, ramp_busy, en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
             en_reg_pwm_15_8, pwm_duty_cycle, ramp_target, ramp_div};
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL outputs vec=%0d {rdy,busy,regs} actual=%h expected=%h", vectors, act, e);
      end
    end
  end

  initial begin
    logic [6:0] a;
    logic [7:0] d;
    bit         hv;
    vectors = 0; miscompares = 0; cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);

    // reset state and basic host writes, including a dropped address
    drive(1, 0, 7'h00, 8'h00);
    idle(1);
    wr(7'h00, 8'hA5); wr(7'h04, 8'h80); wr(7'h07, 8'h11);
    wr(7'h01, 8'h5A); wr(7'h02, 8'h3C); wr(7'h03, 8'hC3); wr(7'h7F, 8'hEE);
    idle(2);

    // ramp up 0x10 -> 0x13, div 1
    wr(7'h04, 8'h10); wr(7'h06, 8'h01); wr(7'h05, 8'h13);
    idle(40);

    // ramp down to 0x00, no wrap
    wr(7'h04, 8'h02); wr(7'h05, 8'h00);
    idle(30);

    // ramp up to 0xFF endpoint with div 0
    wr(7'h06, 8'h00); wr(7'h04, 8'hFD); wr(7'h05, 8'hFF);
    idle(25);

    // continuous host traffic during a ramp
    wr(7'h04, 8'h20); wr(7'h05, 8'h24);
    for (int i = 0; i < 40; i++) wr(7'h00, 8'($urandom));
    idle(5);

    // abort by duty write mid-ramp
    wr(7'h06, 8'h01); wr(7'h05, 8'h40);
    idle(12);
    wr(7'h04, 8'h50);
    idle(15);

    // retarget mid-ramp, then retarget onto current duty
    wr(7'h05, 8'h60); idle(5); wr(7'h05, 8'h45); idle(20);
    wr(7'h05, 8'h30); idle(12); wr(7'h05, m_reg[4]); idle(10);

    // reset mid-ramp
    wr(7'h05, 8'h90); idle(14);
    drive(1, 1, 7'h00, 8'h77);
    idle(3);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      hv = ($urandom_range(0, 99) >= 45);
      a  = 7'($urandom_range(0, 9));
      if (a >= 7'd8) a = 7'($urandom_range(8, 127));
      d  = 8'($urandom);
      if (a == 7'h04) begin
        case ($urandom_range(0, 5))
          0: d = 8'h00; 1: d = 8'hFF; 2: d = 8'h01; 3: d = 8'hFE; default: ;
        endcase
      end
      if (a == 7'h05) d = m_reg[4] + 8'($urandom_range(0, 8)) - 8'd4;
      if (a == 7'h06) d = 8'($urandom_range(0, 2));
      drive($urandom_range(0, 399) == 0, hv, a, d);
    end
    idle(2);

    @(posedge clk);
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain leftover=%0d required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
